soft_error_tmr_reg: RTL and testbench

SOFT_ERROR_TMR_REG -- requirements
Module: soft_error_tmr_reg

---
 rtl/soft_error_tmr_reg.sv | 117 +++++++++++
 tb/tb_soft_error_tmr_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/soft_error_tmr_reg.sv
// Triple-modular-redundant register with continuous scrubbing, a saturating
// mismatch counter and a valid/ready error-report channel.
module soft_error_tmr_reg #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     D,
    input  logic [WIDTH-1:0]     inj_a,
    input  logic [WIDTH-1:0]     inj_b,
    input  logic [WIDTH-1:0]     inj_c,
    output logic [WIDTH-1:0]     Q,
    output logic [CNT_WIDTH-1:0] err_count,
    input  logic                 clr_count,
    output logic                 err_valid,
    input  logic                 err_ready,
    output logic [WIDTH-1:0]     err_bits,
    output logic [1:0]           err_copy,
    output logic                 err_overrun
);

    typedef enum logic {IDLE, REPORT} state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     a_q, b_q, c_q;
    logic [WIDTH-1:0]     next_val, mism, a_min, b_min, c_min;
    logic                 mismatch;
    logic [1:0]           copy_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    state_e               state_q, state_d;
    logic                 capture;
    logic [WIDTH-1:0]     bits_q;
    logic [1:0]           copy_q;
    logic                 ovr_q, ovr_d;

    assign Q        = (a_q & b_q) | (b_q & c_q) | (a_q & c_q);
    assign next_val = en ? D : Q;
    assign mism     = (a_q ^ b_q) | (b_q ^ c_q);
    assign mismatch = |mism;

    // A copy is the minority on a bit when it differs from both others there.
    assign a_min = (a_q ^ b_q) & (a_q ^ c_q);
    assign b_min = (b_q ^ a_q) & (b_q ^ c_q);
    assign c_min = (c_q ^ a_q) & (c_q ^ b_q);

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        copy_d = 2'd3;
        if (mism == a_min)      copy_d = 2'd0;
        else if (mism == b_min) copy_d = 2'd1;
        else if (mism == c_min) copy_d = 2'd2;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_count)
            cnt_d = mismatch ? CNT_ONE : '0;
        else if (mismatch && !(&cnt_q))
            cnt_d = cnt_q + CNT_ONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mismatch) state_d = REPORT;
            REPORT:  if (err_ready && !mismatch) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_valid = (state_q == REPORT);
        capture   = mismatch && (state_q == IDLE || err_ready);
        ovr_d     = ovr_q;
        if (state_q == REPORT) begin
            if (!err_ready && mismatch) ovr_d = 1'b1;
            else if (err_ready)         ovr_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all copies update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
            bits_q <= '0;
            copy_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            a_q   <= next_val ^ inj_a;
            b_q   <= next_val ^ inj_b;
            c_q   <= next_val ^ inj_c;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
            if (capture) begin
                bits_q <= mism;
                copy_q <= copy_d;
            end
        end
    end

    assign err_count   = cnt_q;
    assign err_bits    = bits_q;
    assign err_copy    = copy_q;
    assign err_overrun = ovr_q;

endmodule

// File: tb/tb_soft_error_tmr_reg.sv
// Bench for soft_error_tmr_reg: a per-bit behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_soft_error_tmr_reg;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          en, clr_count, err_ready;
    logic [W-1:0]  D, inj_a, inj_b, inj_c;
    logic [W-1:0]  Q, err_bits;
    logic [CW-1:0] err_count;
    logic          err_valid, err_overrun;
    logic [1:0]    err_copy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    soft_error_tmr_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .en(en), .D(D),
        .inj_a(inj_a), .inj_b(inj_b), .inj_c(inj_c), .Q(Q),
        .err_count(err_count), .clr_count(clr_count),
        .err_valid(err_valid), .err_ready(err_ready),
        .err_bits(err_bits), .err_copy(err_copy), .err_overrun(err_overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: three copies as plain integers, bit-by-bit majority.
    int m_a = 0, m_b = 0, m_c = 0, m_cnt = 0, m_bits = 0, m_copy = 0;
    bit m_valid = 0, m_ovr = 0;

    function automatic int vote(input int a, input int b, input int c);
        int r = 0;
        for (int i = 0; i < W; i++)
            if (a[i] + b[i] + c[i] >= 2) r |= (1 << i);
        return r;
    endfunction

    function automatic int disagree(input int a, input int b, input int c);
        int r = 0;
        for (int i = 0; i < W; i++)
            if (!(a[i] == b[i] && b[i] == c[i])) r |= (1 << i);
        return r;
    endfunction

    function automatic int minority(input int a, input int b, input int c);
        int who = -1;
        for (int i = 0; i < W; i++) begin
            int k;
            if (a[i] == b[i] && b[i] == c[i]) continue;
            k = (b[i] == c[i]) ? 0 : (a[i] == c[i]) ? 1 : 2;
            if (who == -1) who = k;
            else if (who != k) return 3;
        end
        return (who < 0) ? 0 : who;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_a = 0; m_b = 0; m_c = 0; m_cnt = 0;
            m_bits = 0; m_copy = 0; m_valid = 0; m_ovr = 0;
        end else begin
            int mm, nxt;
            mm  = disagree(m_a, m_b, m_c);
            nxt = en ? int'(D) : vote(m_a, m_b, m_c);
            if (clr_count) m_cnt = (mm != 0) ? 1 : 0;
            else if (mm != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
            if (!m_valid || err_ready) begin
                if (m_valid) m_ovr = 0;
                if (mm != 0) begin
                    m_bits  = mm;
                    m_copy  = minority(m_a, m_b, m_c);
                    m_valid = 1;
                end else begin
                    m_valid = 0;
                end
            end else if (mm != 0) begin
                m_ovr = 1;
            end
            m_a = nxt ^ int'(inj_a);
            m_b = nxt ^ int'(inj_b);
            m_c = nxt ^ int'(inj_c);
        end
    end

    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            check("model_Q",       32'(Q),           32'(vote(m_a, m_b, m_c)));
            check("model_count",   32'(err_count),   32'(m_cnt));
            check("model_valid",   32'(err_valid),   32'(m_valid));
            check("model_overrun", 32'(err_overrun), 32'(m_ovr));
            if (m_valid) begin
                check("model_bits", 32'(err_bits), 32'(m_bits));
                check("model_copy", 32'(err_copy), 32'(m_copy));
            end
        end
    end

    // Apply one cycle of inputs, let the edge pass, return at the next negedge.
    task automatic cyc(input logic e, input logic [W-1:0] d,
                       input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic,
                       input logic rdy, input logic clr);
        en = e; D = d; inj_a = ia; inj_b = ib; inj_c = ic;
        err_ready = rdy; clr_count = clr;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; en = 0; D = 0; inj_a = 0; inj_b = 0; inj_c = 0;
        clr_count = 0; err_ready = 0;
        repeat (2) @(negedge clock);
        check("rst_Q",     32'(Q),         32'h0);
        check("rst_valid", 32'(err_valid), 32'h0);
        check("rst_count", 32'(err_count), 32'h0);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Plain load: one-cycle latency
        cyc(1, 8'hA5, 0, 0, 0, 0, 0);
        check("load_Q",     32'(Q),         32'hA5);
        check("load_count", 32'(err_count), 32'h0);
        check("load_valid", 32'(err_valid), 32'h0);

        // Single upset in B, scrubbed next cycle
        cyc(0, 0, 0, 8'h01, 0, 0, 0);
        check("b_upset_Q", 32'(Q), 32'hA5);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("b_valid", 32'(err_valid), 32'h1);
        check("b_bits",  32'(err_bits),  32'h01);
        check("b_copy",  32'(err_copy),  32'h1);
        check("b_count", 32'(err_count), 32'h1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("b_done_valid", 32'(err_valid), 32'h0);
        check("b_done_count", 32'(err_count), 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("clr_no_mism", 32'(err_count), 32'h0);

        // Two copies upset on different bits, then overrun while stalled
        cyc(0, 0, 8'h10, 0, 8'h02, 0, 0);
        check("ac_Q", 32'(Q), 32'hA5);
        cyc(0, 0, 8'h80, 0, 0, 0, 0);
        check("ac_bits", 32'(err_bits), 32'h12);
        check("ac_copy", 32'(err_copy), 32'h3);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("ovr_set",   32'(err_overrun), 32'h1);
        check("ovr_bits",  32'(err_bits),    32'h12);
        check("ovr_count", 32'(err_count),   32'h2);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("ovr_clear", 32'(err_overrun), 32'h0);
        check("ovr_idle",  32'(err_valid),   32'h0);
        cyc(0, 0, 0, 0, 0, 0, 1);

        // Same bit upset in two copies: vote is wrong, scrub propagates it
        cyc(0, 0, 8'h04, 8'h04, 0, 0, 0);
        check("dbl_Q", 32'(Q), 32'hA1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("dbl_valid", 32'(err_valid), 32'h1);
        check("dbl_bits",  32'(err_bits),  32'h04);
        check("dbl_copy",  32'(err_copy),  32'h2);
        check("dbl_Q2",    32'(Q),         32'hA1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("dbl_idle", 32'(err_valid), 32'h0);

        // Counter saturation at CNT_WIDTH=2
        cyc(0, 0, 0, 8'h01, 0, 1, 0);
        check("sat0", 32'(err_count), 32'h0);
        cyc(0, 0, 0, 8'h01, 0, 1, 0);
        check("sat1", 32'(err_count), 32'h1);
        cyc(0, 0, 0, 8'h01, 0, 1, 0);
        check("sat2", 32'(err_count), 32'h2);
        cyc(0, 0, 0, 8'h01, 0, 1, 0);
        check("sat3", 32'(err_count), 32'h3);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("sat4", 32'(err_count), 32'h3);
        cyc(0, 0, 0, 8'h01, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("clr_with_mism", 32'(err_count), 32'h1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("clr_without", 32'(err_count), 32'h0);

        // Async reset mid-report
        cyc(0, 0, 0, 8'h01, 0, 0, 0);
        cyc(0, 0, 0, 8'h01, 0, 0, 0);
        cyc(0, 0, 0, 8'h01, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("pre_rst_valid", 32'(err_valid), 32'h1);
        check("pre_rst_count", 32'(err_count), 32'h3);
        #1 reset = 1'b1;
        #1;
        check("arst_Q",     32'(Q),           32'h0);
        check("arst_count", 32'(err_count),   32'h0);
        check("arst_valid", 32'(err_valid),   32'h0);
        check("arst_bits",  32'(err_bits),    32'h0);
        check("arst_copy",  32'(err_copy),    32'h0);
        check("arst_ovr",   32'(err_overrun), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cyc(1, 8'h3C, 0, 0, 0, 0, 0);
        check("post_rst_Q", 32'(Q), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
